axil_csr_slave: RTL

AXIL_CSR_SLAVE -- requirements
Module: axil_csr_slave

---
 rtl/axil_csr_pkg.sv | 10 +
 rtl/axil_hold_reg.sv | 37 +++
 rtl/axil_csr_slave.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/axil_csr_pkg.sv
// Shared constants for the AXI-Lite CSR slave: response codes, address
// alignment and the default identification word.
package axil_csr_pkg;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [1:0]  RESP_SLVERR      = 2'b10;
  localparam int          ADDR_LSB         = 2;
  localparam logic [31:0] DEFAULT_ID_VALUE = 32'h0F5C_0001;

endpackage

// File: rtl/axil_hold_reg.sv
// One-entry valid+payload holding register. It accepts a beat whenever it
// is empty and keeps it until the consumer pulses i_clear.
module axil_hold_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_clear,
  output logic             o_held,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Ready is suppressed during reset so no handshake can be seen then.
  assign o_ready = !r_valid && !srst;
  assign o_held  = r_valid;
  assign o_data  = r_data;

  // Capture when empty, release when the consumer has used the entry.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_valid && o_ready) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axil_csr_slave.sv
// AXI-Lite register file: register 0 is a read-only ID word, registers
// 1..NUM_REGS-1 are byte-writable. One outstanding write and one
// outstanding read, running independently of each other.
module axil_csr_slave
  import axil_csr_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DEFAULT_ID_VALUE
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           axi_lite_awvalid_i,
  output logic                           axi_lite_awready_o,
  input  logic [ADDR_WIDTH-1:0]          axi_lite_awaddr_i,
  input  logic [2:0]                     axi_lite_awprot_i,
  input  logic                           axi_lite_wvalid_i,
  output logic                           axi_lite_wready_o,
  input  logic [DATA_WIDTH-1:0]          axi_lite_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        axi_lite_wstrb_i,
  output logic                           axi_lite_bvalid_o,
  input  logic                           axi_lite_bready_i,
  output logic [1:0]                     axi_lite_bresp_o,
  input  logic                           axi_lite_arvalid_i,
  output logic                           axi_lite_arready_o,
  input  logic [ADDR_WIDTH-1:0]          axi_lite_araddr_i,
  input  logic [2:0]                     axi_lite_arprot_i,
  output logic                           axi_lite_rvalid_o,
  input  logic                           axi_lite_rready_i,
  output logic [DATA_WIDTH-1:0]          axi_lite_rdata_o,
  output logic [1:0]                     axi_lite_rresp_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] csr_regs_o
);

  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam int HI_SHIFT = ADDR_LSB + IDX_W;
  localparam int SW       = DATA_WIDTH / 8;

  logic                  w_aw_held;
  logic [ADDR_WIDTH-1:0] w_aw_addr;
  logic                  w_w_held;
  logic [DATA_WIDTH-1:0] w_w_data;
  logic [SW-1:0]         w_w_strb;
  logic                  w_commit;
  logic [IDX_W-1:0]      w_wr_idx;
  logic                  w_wr_ok;
  logic                  w_ar_hs;
  logic [IDX_W-1:0]      w_rd_idx;
  logic                  w_rd_in_range;
  logic                  w_unused;

  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  // Protection bits carry no meaning for this register file.
  assign w_unused = ^{axi_lite_awprot_i, axi_lite_arprot_i};

  axil_hold_reg #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
    .clk     (aclk),
    .srst    (areset),
    .i_valid (axi_lite_awvalid_i),
    .o_ready (axi_lite_awready_o),
    .i_data  (axi_lite_awaddr_i),
    .i_clear (w_commit),
    .o_held  (w_aw_held),
    .o_data  (w_aw_addr)
  );

  axil_hold_reg #(.WIDTH(DATA_WIDTH + SW)) u_w_hold (
    .clk     (aclk),
    .srst    (areset),
    .i_valid (axi_lite_wvalid_i),
    .o_ready (axi_lite_wready_o),
    .i_data  ({axi_lite_wstrb_i, axi_lite_wdata_i}),
    .i_clear (w_commit),
    .o_held  (w_w_held),
    .o_data  ({w_w_strb, w_w_data})
  );

  // A pending B response blocks the next commit, which bounds writes to
  // one every two cycles and keeps bresp stable while it waits.
  assign w_commit = w_aw_held && w_w_held && !r_bvalid;
  assign w_wr_idx = w_aw_addr[ADDR_LSB +: IDX_W];
  assign w_wr_ok  = ((w_aw_addr >> HI_SHIFT) == '0) && (w_wr_idx != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_id
        assign csr_regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = ID_VALUE;
      end else begin : g_rw
        logic [DATA_WIDTH-1:0] r_reg;

        // Byte-lane update of this register on a successful commit.
        always_ff @(posedge aclk) begin
          if (areset) begin
            r_reg <= '0;
          end else if (w_commit && w_wr_ok && (w_wr_idx == IDX_W'(gi))) begin
            for (int b = 0; b < SW; b++) begin
              if (w_w_strb[b]) begin
                r_reg[8*b +: 8] <= w_w_data[8*b +: 8];
              end
            end
          end
        end

        assign csr_regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = r_reg;
      end
    end
  endgenerate

  // Write response: raised the cycle after commit, dropped on handshake.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_bvalid && axi_lite_bready_i) begin
      r_bvalid <= 1'b0;
    end
  end

  assign axi_lite_bvalid_o = r_bvalid;
  assign axi_lite_bresp_o  = r_bresp;

  assign axi_lite_arready_o = !r_rvalid && !areset;
  assign w_ar_hs            = axi_lite_arvalid_i && axi_lite_arready_o;
  assign w_rd_idx           = axi_lite_araddr_i[ADDR_LSB +: IDX_W];
  assign w_rd_in_range      = (axi_lite_araddr_i >> HI_SHIFT) == '0;

  // Read data is sampled from the register image before any same-cycle
  // commit lands, so a colliding read returns the old value.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      if (w_rd_in_range) begin
        r_rdata <= csr_regs_o[w_rd_idx*DATA_WIDTH +: DATA_WIDTH];
        r_rresp <= RESP_OKAY;
      end else begin
        r_rdata <= '0;
        r_rresp <= RESP_SLVERR;
      end
    end else if (r_rvalid && axi_lite_rready_i) begin
      r_rvalid <= 1'b0;
    end
  end

  assign axi_lite_rvalid_o = r_rvalid;
  assign axi_lite_rdata_o  = r_rdata;
  assign axi_lite_rresp_o  = r_rresp;

endmodule
